// File: rtl/spike_event_detector.sv
// Spike event detector: turns a stream of IEEE-754 membrane samples into spike strobes,
// a saturating spike count and the last inter-spike interval, gated by a re-arm hysteresis.
module spike_event_detector #(
  parameter logic [31:0] THRESH      = 32'hC1A00000,
  parameter logic [31:0] REARM       = 32'hC2480000,
  parameter int unsigned REFRACT_CYC = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        vpost_valid,
  input  logic [31:0] vpost,
  output logic        spike_pulse,
  output logic [15:0] spike_count,
  output logic [15:0] isi,
  output logic        isi_valid,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    S_WAIT_REARM = 2'd0,
    S_ARMED      = 2'd1,
    S_REFRACT    = 2'd2
  } state_t;

  localparam logic [7:0]  REFRACT_LD = 8'(REFRACT_CYC);
  localparam logic [15:0] SAT16      = 16'hFFFF;

  function automatic logic is_nan(input logic [31:0] f);
    return (&f[30:23]) && (|f[22:0]);
  endfunction

  // Maps a float onto an unsigned key with the same ordering; -0 is folded onto +0 first.
  function automatic logic [31:0] ord_key(input logic [31:0] f);
    logic [31:0] g;
    g = (f[30:0] == 31'd0) ? 32'd0 : f;
    return g[31] ? ~g : {1'b1, g[30:0]};
  endfunction

  localparam logic [31:0] THRESH_KEY = ord_key(THRESH);
  localparam logic [31:0] REARM_KEY  = ord_key(REARM);

  state_t      state_q, state_d;
  logic [7:0]  refr_q, refr_d;
  logic [15:0] ivl_q, ivl_d;
  logic [15:0] count_q, count_d;
  logic [15:0] isi_q, isi_d;
  logic        pulse_q, pulse_d;
  logic        isiv_q, isiv_d;
  logic        detect;

  logic [31:0] v_key;
  logic        ge_thresh, lt_rearm, accept;

  assign v_key     = ord_key(vpost);
  assign ge_thresh = !is_nan(vpost) && (v_key >= THRESH_KEY);
  assign lt_rearm  = !is_nan(vpost) && (v_key < REARM_KEY);
  assign accept    = enable && vpost_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_WAIT_REARM;
      refr_q  <= 8'd0;
      ivl_q   <= 16'd0;
      count_q <= 16'd0;
      isi_q   <= 16'd0;
      pulse_q <= 1'b0;
      isiv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      refr_q  <= refr_d;
      ivl_q   <= ivl_d;
      count_q <= count_d;
      isi_q   <= isi_d;
      pulse_q <= pulse_d;
      isiv_q  <= isiv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    detect  = 1'b0;
    if (enable) begin
      case (state_q)
        S_WAIT_REARM: if (accept && lt_rearm) state_d = S_ARMED;
        S_ARMED: begin
          if (accept && ge_thresh) begin
            detect  = 1'b1;
            state_d = (REFRACT_LD == 8'd0) ? S_WAIT_REARM : S_REFRACT;
          end
        end
        S_REFRACT: if (refr_q <= 8'd1) state_d = S_WAIT_REARM;
        default:   state_d = S_WAIT_REARM;
      endcase
    end
  end

  // Counters and registered outputs; with enable low everything holds except the strobe.
  always_comb begin
    refr_d  = refr_q;
    ivl_d   = ivl_q;
    count_d = count_q;
    isi_d   = isi_q;
    isiv_d  = isiv_q;
    pulse_d = 1'b0;
    if (enable) begin
      pulse_d = detect;
      if (detect) begin
        refr_d  = REFRACT_LD;
        ivl_d   = 16'd0;
        count_d = (count_q == SAT16) ? SAT16 : count_q + 16'd1;
        isi_d   = (ivl_q == SAT16) ? SAT16 : ivl_q + 16'd1;
        isiv_d  = isiv_q || (count_q != 16'd0);
      end else begin
        ivl_d = (ivl_q == SAT16) ? SAT16 : ivl_q + 16'd1;
        if (state_q == S_REFRACT && refr_q != 8'd0) refr_d = refr_q - 8'd1;
      end
    end
  end

  assign spike_pulse = pulse_q;
  assign spike_count = count_q;
  assign isi         = isi_q;
  assign isi_valid   = isiv_q;
  assign state       = state_q;

endmodule

// File: doc/spike_event_detector.md
SPIKE_EVENT_DETECTOR -- requirements
Module: spike_event_detector

Interface
REQ-001 Parameter THRESH, default 32'hC1A00000 (-20.0), IEEE-754 single-precision spike threshold.
REQ-002 Parameter REARM, default 32'hC2480000 (-50.0), IEEE-754 single-precision re-arm level; REARM < THRESH.
REQ-003 Parameter REFRACT_CYC, default 4, refractory length in enabled cycles, range 0..255.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  advance enable; when low, all state and outputs hold.
REQ-007 vpost_valid  input  1  vpost carries a new membrane sample this cycle.
REQ-008 vpost  input  32  postsynaptic membrane potential (Vpostx1), IEEE-754 single.
REQ-009 spike_pulse  output  1  one-cycle spike event strobe.
REQ-010 spike_count  output  16  spikes detected since reset, saturating.
REQ-011 isi  output  16  last inter-spike interval in enabled cycles, saturating.
REQ-012 isi_valid  output  1  isi holds a real interval (at least two spikes seen).
REQ-013 state  output  2  FSM state: 0 WAIT_REARM, 1 ARMED, 2 REFRACT.

Function
REQ-014 Comparison: finite IEEE-754 ordering; +0 equals -0; denormals compared by bit value; infinities ordered.
REQ-015 A NaN sample is neither >= THRESH nor < REARM and causes no transition.
REQ-016 A sample is accepted only when enable=1 and vpost_valid=1; enable=0 freezes FSM, counters, and outputs, and forces spike_pulse=0.
REQ-017 WAIT_REARM -> ARMED when an accepted sample is < REARM.
REQ-018 ARMED -> REFRACT when an accepted sample is >= THRESH (the detection cycle); refractory counter loads REFRACT_CYC.
REQ-019 REFRACT: counter decrements each enabled cycle regardless of vpost_valid; on the cycle the counter reads 1 the FSM goes to WAIT_REARM.
REQ-020 REFRACT_CYC=0: ARMED -> WAIT_REARM directly on detection, with REFRACT skipped.
REQ-021 Samples arriving in REFRACT are ignored.
REQ-022 spike_pulse asserts on the clock edge after the detection cycle (latency 1), for exactly one cycle.
REQ-023 spike_count increments with spike_pulse and holds at 16'hFFFF once reached.
REQ-024 Interval counter increments each enabled cycle, saturates at 16'hFFFF, and is cleared on each detection.
REQ-025 isi loads the interval counter value +1 (saturating) with spike_pulse, giving the enabled-cycle distance between consecutive detection cycles.
REQ-026 isi_valid rises with the second spike_pulse after reset and stays high until reset.
REQ-027 A sample that is >= THRESH while in WAIT_REARM never produces a spike, which prevents double counting on a broad spike.

Reset
REQ-028 reset=1 at a clock edge, regardless of enable, sets state=WAIT_REARM, spike_pulse=0, spike_count=0, isi=0, isi_valid=0, and clears the refractory and interval counters.
REQ-029 reset asserted mid-REFRACT or in the same cycle as a detection wins: no pulse and no count.
REQ-030 After reset the block starts in WAIT_REARM, so a membrane starting above threshold cannot spike until it first drops below REARM.

Verification
REQ-031 Reset, then vpost=-65.0 (C2820000) valid, then +30.0 (41F00000) valid -> state 0->1->2; spike_pulse=1 exactly 1 cycle after the +30.0 sample; spike_count=1; isi_valid=0.
REQ-032 Two spikes with detection cycles 100 enabled cycles apart (re-armed with -65.0 between them) -> isi=100, isi_valid=1, spike_count=2.
REQ-033 REFRACT_CYC=4, +30.0 held valid for 10 cycles after detection -> single spike_pulse; state=WAIT_REARM after 4 cycles; no further spikes until a sample below -50.0 arrives.
REQ-034 NaN (7FC00000) and -35.0 (C20C0000) while ARMED -> no transition and no pulse; -20.0 exactly (C1A00000) -> spike.
REQ-035 enable=0 for 50 cycles with +30.0 valid while ARMED -> no pulse and counters frozen; enable=1 -> spike 1 cycle later; isi excludes the disabled cycles.
REQ-036 reset pulsed while in REFRACT with spike_count=3 -> next cycle all outputs are 0 and state=0; a subsequent +30.0 sample produces no spike.
